// File: rtl/led_ctrl_pkg.sv
// Shared types and default rates for the LED bar position/blink controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    SOLID = 2'd0,
    SLOW  = 2'd1,
    FAST  = 2'd2,
    OFF   = 2'd3
  } blink_mode_t;

  localparam int DEF_N_LEDS    = 16;
  localparam int DEF_CLK_HZ    = 100_000_000;
  localparam int DEF_SLOW_HZ   = 1;
  localparam int DEF_FAST_HZ   = 2;
  localparam int DEF_SCROLL_HZ = 4;

  function automatic blink_mode_t next_mode(input blink_mode_t m);
    case (m)
      SOLID:   return SLOW;
      SLOW:    return FAST;
      FAST:    return OFF;
      default: return SOLID;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Prescaler counting 0..DIV-1 while enabled; one-cycle tick on terminal count.
// A clear in the same cycle suppresses the tick and restarts the count.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: DIV must be >= 1");
  end

  logic [CW-1:0] cnt;

  assign tick = en & ~clr & (cnt == TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// One-hot LED bar position controller with blink modes, auto-scroll and home.
//   state | meaning
//   SOLID | LED at pos steadily lit
//   SLOW  | LED at pos blinks at SLOW_HZ
//   FAST  | LED at pos blinks at FAST_HZ
//   OFF   | all LEDs dark, position still tracked
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_LEDS    = DEF_N_LEDS,
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int SLOW_HZ   = DEF_SLOW_HZ,
  parameter int FAST_HZ   = DEF_FAST_HZ,
  parameter int SCROLL_HZ = DEF_SCROLL_HZ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode_pls,
  input  logic                      left_pls,
  input  logic                      right_pls,
  input  logic                      auto_pls,
  input  logic                      home_pls,
  output logic [N_LEDS-1:0]         led,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic [1:0]                mode,
  output logic                      auto_on
);

  localparam int PW         = $clog2(N_LEDS);
  localparam int SLOW_DIV   = CLK_HZ / (2 * SLOW_HZ);
  localparam int FAST_DIV   = CLK_HZ / (2 * FAST_HZ);
  localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  if (N_LEDS < 2) begin : g_bad_n
    $error("led_pattern_ctrl: N_LEDS must be >= 2");
  end
  if (SLOW_DIV < 1 || FAST_DIV < 1 || SCROLL_DIV < 1) begin : g_bad_div
    $error("led_pattern_ctrl: a rate exceeds what CLK_HZ can divide down to");
  end

  blink_mode_t   mode_q;
  logic          phase_q;
  logic [PW-1:0] pos_q;
  logic          auto_q;

  logic          manual;
  logic          blink_clr;
  logic          scroll_clr;
  logic          slow_tick;
  logic          fast_tick;
  logic          scroll_tick;
  logic [PW-1:0] pos_inc;
  logic [PW-1:0] pos_dec;

  // Any pulse that restarts a prescaler also swallows a tick landing in the same cycle.
  assign manual     = left_pls | right_pls;
  assign blink_clr  = home_pls | mode_pls;
  assign scroll_clr = home_pls | auto_pls | manual;

  assign pos_inc = (pos_q == LAST) ? '0 : pos_q + 1'b1;
  assign pos_dec = (pos_q == '0) ? LAST : pos_q - 1'b1;

  tick_gen #(.DIV(SLOW_DIV)) u_slow_tick (
    .clk   (clk),
    .reset (reset),
    .en    (mode_q == SLOW),
    .clr   (blink_clr),
    .tick  (slow_tick)
  );

  tick_gen #(.DIV(FAST_DIV)) u_fast_tick (
    .clk   (clk),
    .reset (reset),
    .en    (mode_q == FAST),
    .clr   (blink_clr),
    .tick  (fast_tick)
  );

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .clk   (clk),
    .reset (reset),
    .en    (auto_q),
    .clr   (scroll_clr),
    .tick  (scroll_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= SOLID;
      phase_q <= 1'b1;
      pos_q   <= '0;
      auto_q  <= 1'b0;
    end else if (home_pls) begin
      mode_q  <= SOLID;
      phase_q <= 1'b1;
      pos_q   <= '0;
      auto_q  <= 1'b0;
    end else begin
      if (mode_pls) begin
        mode_q  <= next_mode(mode_q);
        phase_q <= 1'b1;
      end else if (slow_tick | fast_tick) begin
        phase_q <= ~phase_q;
      end

      if (left_pls && !right_pls) begin
        pos_q <= pos_inc;
      end else if (right_pls && !left_pls) begin
        pos_q <= pos_dec;
      end else if (!manual && scroll_tick) begin
        pos_q <= pos_inc;
      end

      if (auto_pls) begin
        auto_q <= ~auto_q;
      end
    end
  end

  logic [N_LEDS-1:0] one_hot;
  assign one_hot = {{(N_LEDS-1){1'b0}}, 1'b1} << pos_q;

  assign led     = (mode_q == OFF) ? '0 : (one_hot & {N_LEDS{phase_q}});
  assign pos     = pos_q;
  assign mode    = mode_q;
  assign auto_on = auto_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: table vectors, directed corner cases, random vs model.
module tb_led_pattern_ctrl;

  localparam int N          = 10;
  localparam int CLK_HZ     = 40;
  localparam int SLOW_HZ    = 1;
  localparam int FAST_HZ    = 2;
  localparam int SCROLL_HZ  = 4;
  localparam int SLOW_HALF  = CLK_HZ / (2 * SLOW_HZ);
  localparam int FAST_HALF  = CLK_HZ / (2 * FAST_HZ);
  localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;

  localparam logic [4:0] P_MODE = 5'b00001;
  localparam logic [4:0] P_L    = 5'b00010;
  localparam logic [4:0] P_R    = 5'b00100;
  localparam logic [4:0] P_A    = 5'b01000;
  localparam logic [4:0] P_H    = 5'b10000;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode_pls, left_pls, right_pls, auto_pls, home_pls;
  logic [N-1:0] led;
  logic [3:0]   pos;
  logic [1:0]   mode;
  logic         auto_on;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .N_LEDS    (N),
    .CLK_HZ    (CLK_HZ),
    .SLOW_HZ   (SLOW_HZ),
    .FAST_HZ   (FAST_HZ),
    .SCROLL_HZ (SCROLL_HZ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_pls  (mode_pls),
    .left_pls  (left_pls),
    .right_pls (right_pls),
    .auto_pls  (auto_pls),
    .home_pls  (home_pls),
    .led       (led),
    .pos       (pos),
    .mode      (mode),
    .auto_on   (auto_on)
  );

  // Behavioural model: ages in cycles since the last restart of each timebase.
  int m_pos, m_mode, m_blink_age, m_scroll_age;
  bit m_auto;

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_auto = 0; m_blink_age = 0; m_scroll_age = 0;
  endtask

  task automatic model_step(input logic [4:0] p);
    bit l, r, clr, step;
    if (p[4]) begin
      model_reset();
    end else begin
      l = p[1]; r = p[2];
      clr  = p[3] | l | r;
      step = m_auto && !clr && (m_scroll_age % SCROLL_DIV == SCROLL_DIV - 1);
      if (clr) m_scroll_age = 0;
      else if (m_auto) m_scroll_age++;
      if (l && !r) m_pos = (m_pos + 1) % N;
      else if (r && !l) m_pos = (m_pos + N - 1) % N;
      else if (!(l || r) && step) m_pos = (m_pos + 1) % N;
      if (p[3]) m_auto = !m_auto;
      if (p[0]) begin
        m_mode = (m_mode + 1) % 4;
        m_blink_age = 0;
      end else begin
        m_blink_age++;
      end
    end
  endtask

  function automatic logic [31:0] oh(input int p);
    logic [31:0] one;
    one = 32'd1;
    return one << p;
  endfunction

  function automatic logic [31:0] model_led();
    bit lit;
    if (m_mode == 3) return 32'd0;
    if (m_mode == 1)      lit = ((m_blink_age / SLOW_HALF) % 2) == 0;
    else if (m_mode == 2) lit = ((m_blink_age / FAST_HALF) % 2) == 0;
    else                  lit = 1'b1;
    return lit ? oh(m_pos) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pos"},  32'(pos),     32'(m_pos));
    check({tag, "_mode"}, 32'(mode),    32'(m_mode));
    check({tag, "_auto"}, 32'(auto_on), 32'(m_auto));
    check({tag, "_led"},  32'(led),     model_led());
  endtask

  task automatic apply(input logic [4:0] p, input string tag);
    {home_pls, auto_pls, right_pls, left_pls, mode_pls} = p;
    @(posedge clk);
    #1;
    {home_pls, auto_pls, right_pls, left_pls, mode_pls} = 5'b0;
    model_step(p);
    check_model(tag);
  endtask

  task automatic run_led(input int n, input logic [31:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(5'b0, tag);
      check({tag, "_exp"}, 32'(led), exp);
    end
  endtask

  task automatic run_pos(input int n, input int exp, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(5'b0, tag);
      check({tag, "_exp"}, 32'(pos), 32'(exp));
    end
  endtask

  typedef struct {
    logic [4:0] p;
    int         e_pos;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 1; i <= 9; i++) tbl.push_back('{P_L, i});
    tbl.push_back('{P_L, 0});
    tbl.push_back('{P_R, 9});
    for (int i = 8; i >= 4; i--) tbl.push_back('{P_R, i});
    tbl.push_back('{P_L | P_R, 4});
    tbl.push_back('{P_H | P_L, 0});
    for (int i = 1; i <= 4; i++) tbl.push_back('{P_L, i});

    reset = 1'b0;
    {home_pls, auto_pls, right_pls, left_pls, mode_pls} = 5'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_auto", 32'(auto_on), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_led", 32'(led), 32'd1);

    // Position wrap, simultaneous left/right, home priority.
    foreach (tbl[i]) begin
      apply(tbl[i].p, "tbl");
      check("tbl_pos", 32'(pos), 32'(tbl[i].e_pos));
      check("tbl_led", 32'(led), oh(tbl[i].e_pos));
      check("tbl_mode", 32'(mode), 32'd0);
    end

    // SLOW: 20 lit / 20 dark; switch to FAST mid-dark relights at once.
    apply(P_MODE, "slow_in");
    check("slow_mode", 32'(mode), 32'd1);
    check("slow_first", 32'(led), oh(4));
    run_led(19, oh(4), "slow_on1");
    run_led(20, 32'd0, "slow_off1");
    run_led(20, oh(4), "slow_on2");
    run_led(10, 32'd0, "slow_off2");
    apply(P_MODE, "fast_in");
    check("fast_mode", 32'(mode), 32'd2);
    check("fast_first", 32'(led), oh(4));
    run_led(9, oh(4), "fast_on1");
    run_led(10, 32'd0, "fast_off1");
    run_led(10, oh(4), "fast_on2");

    // OFF then back to SOLID.
    apply(P_MODE, "off_in");
    check("off_mode", 32'(mode), 32'd3);
    check("off_first", 32'(led), 32'd0);
    run_led(99, 32'd0, "off_hold");
    apply(P_MODE, "solid_in");
    check("solid_mode", 32'(mode), 32'd0);
    run_led(20, oh(4), "solid_hold");

    // Auto-scroll from pos 8, manual right on a scroll tick.
    for (int i = 0; i < 4; i++) apply(P_L, "to8");
    check("at8", 32'(pos), 32'd8);
    apply(P_A, "auto_on");
    check("auto_flag", 32'(auto_on), 32'd1);
    run_pos(9, 8, "scr_wait1");
    run_pos(1, 9, "scr_step1");
    run_pos(9, 9, "scr_wait2");
    run_pos(1, 0, "scr_step2");
    run_pos(9, 0, "scr_wait3");
    apply(P_R, "scr_manual");
    check("scr_manual_pos", 32'(pos), 32'd9);
    run_pos(9, 9, "scr_wait4");
    run_pos(1, 0, "scr_step3");

    // Async reset mid-FAST with auto-scroll running.
    apply(P_A, "setup");
    apply(P_MODE, "setup");
    apply(P_MODE, "setup");
    for (int i = 0; i < 4; i++) apply(P_R, "setup");
    apply(P_A, "setup");
    check("pre_rst_pos", 32'(pos), 32'd6);
    check("pre_rst_mode", 32'(mode), 32'd2);
    check("pre_rst_auto", 32'(auto_on), 32'd1);
    run_pos(3, 6, "pre_rst");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_pos", 32'(pos), 32'd0);
    check("arst_mode", 32'(mode), 32'd0);
    check("arst_auto", 32'(auto_on), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_rel_led", 32'(led), 32'd1);
    run_led(30, 32'd1, "arst_after");

    // Random pulses against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] p;
      p[0] = ($urandom_range(0, 39) == 0);
      p[1] = ($urandom_range(0, 5) == 0);
      p[2] = ($urandom_range(0, 5) == 0);
      p[3] = ($urandom_range(0, 59) == 0);
      p[4] = ($urandom_range(0, 299) == 0);
      apply(p, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
